butterfly_pipe: RTL and testbench
=================================

// Module: butterfly_pipe
// PURPOSE
//  Parametrised, fully pipelined radix-2 butterfly for the Kyber NTT/INTT datapath.
//  Per beat it selects Cooley-Tukey (NTT), Gentleman-Sande (INTT) or bypass, and
//  carries mode and a tag down the pipe. The pipe stalls under a valid/ready handshake.
//  Sits between the coefficient-RAM read mux and the write-back address generator.
// PARAMETERS
//  W         16    coefficient width; all data ports are W bits
//  Q         3329  modulus; Q < 2^(W-1), odd
//  QINV      3327  -Q^-1 mod 2^W, used by the Montgomery reduction
//  TAG_W     8     width of the sideband tag (write-back address)
//  HALF_INTT 1     1: INTT outputs are multiplied by 2^-1 mod Q; 0: no scaling
// PORTS
//  clk        in   1      clock; all logic on the rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block can accept a beat this cycle
//  in_mode    in   2      00 NTT, 01 INTT, 10 bypass, 11 idle
//  in_a       in   W      coefficient a, must be < Q
//  in_b       in   W      coefficient b, must be < Q
//  in_w       in   W      twiddle in Montgomery form (w*2^W mod Q), < Q
//  in_tag     in   TAG_W  sideband, returned unchanged
//  out_valid  out  1      output beat valid
//  out_ready  in   1      downstream accepts the beat
//  out_c      out  W      result c, fully reduced to [0,Q)
//  out_d      out  W      result d, fully reduced to [0,Q)
//  out_tag    out  TAG_W  tag of the beat
//  out_mode   out  2      mode of the beat
// BEHAVIOUR
//  - mont(x) = x*2^-W mod Q with a final conditional subtract, so results lie in [0,Q).
//    half(x) = x/2 if x is even, else (x+Q)/2.
//  - NTT:    t=mont(b*w); c=(a+t) mod Q; d=(a-t) mod Q.
//  - INTT:   c=(a+b) mod Q; d=mont(((a-b) mod Q)*w).
//            When HALF_INTT=1, c=half(c) and d=half(d).
//  - Bypass: c=a, d=b. Bypass beats take the same latency, so beat order is preserved.
//  - Idle (11) with in_valid=1: the beat is accepted (handshake completes) and dropped.
//    No output beat is produced.
//  - Four register stages. Latency is exactly 4 advancing cycles from input handshake
//    to out_valid, identical for every mode.
//    NTT stages:  S1 product, S2 mont, S3 add/sub, S4 output register.
//    INTT stages: S1 add/sub, S2 product, S3 mont, S4 halve plus output register.
//  - Each stage has a valid bit. Global advance = !out_valid | out_ready; in_ready = advance.
//    Combinational in_ready depends on out_ready, with no other combinational path.
//    When advance=0 all stage registers and outputs hold.
//  - out_c, out_d, out_tag and out_mode are stable while out_valid=1 and out_ready=0.
//  - Throughput: 1 beat/cycle while out_ready stays high. Bubbles propagate as valid=0.
//  - Reset: every stage valid bit clears and out_valid=0. out_c, out_d, out_tag and
//    out_mode reset to 0. A reset mid-operation discards all in-flight beats.
//    in_ready=1 in the first cycle after reset.
//  - Inputs >= Q give undefined results. The bench asserts that the inputs are < Q.
//  - Arithmetic widths:
//    products are 2W bits;
//    add/sub use W+1 bits with one conditional +Q/-Q correction;
//    mont intermediate is 2W+1 bits.
// TESTING (Q=3329, W=16; Montgomery "1" = 2285)
//  1. NTT a=100, b=50, w=2285 -> c=150, d=50, out_valid exactly 4 cycles after the handshake.
//  2. NTT wrap: a=3000, b=1000, w=2285 -> c=671. Then a=10, b=20, w=2285 -> d=3319.
//  3. INTT with HALF_INTT=1:
//     a=100, b=50, w=2285 -> c=75, d=25.
//     a=1, b=0, w=2285 -> c=1665, d=1665.
//  4. Stream 8 back-to-back beats with mixed NTT, INTT, bypass and idle modes.
//     Hold out_ready=0 for 3 cycles mid-stream.
//     -> every non-idle beat comes out in order with its tag; idle beats produce no
//        output; outputs stay stable while stalled; no beat is lost or duplicated.
//  5. Assert rst for 1 cycle with 3 beats in flight.
//     -> out_valid=0 and outputs=0 on the next cycle; no stale beat ever emerges.
//  6. Random regression: 10k beats against a reference model with random out_ready,
//     all modes, and both values of HALF_INTT -> zero mismatches.

Source files
------------

// File: rtl/butterfly_pipe.sv
// Four-stage radix-2 butterfly for the Kyber NTT/INTT datapath: Cooley-Tukey,
// Gentleman-Sande or bypass per beat, with mode and tag carried down a stallable pipe.
module butterfly_pipe #(
    parameter int unsigned W         = 16,
    parameter int unsigned Q         = 3329,
    parameter int unsigned QINV      = 3327,
    parameter int unsigned TAG_W     = 8,
    parameter int unsigned HALF_INTT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [W-1:0]     in_w,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_c,
    output logic [W-1:0]     out_d,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       out_mode
);

    localparam logic [1:0]   MODE_NTT  = 2'b00;
    localparam logic [1:0]   MODE_INTT = 2'b01;
    localparam logic [1:0]   MODE_IDLE = 2'b11;
    localparam logic [W-1:0] Q_W       = W'(Q);
    localparam logic [W-1:0] QINV_W    = W'(QINV);
    localparam logic [W:0]   Q_X       = (W+1)'(Q);
    localparam logic [2*W:0] Q_M       = (2*W+1)'(Q);

    function automatic logic [W-1:0] add_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= Q_X) s = s - Q_X;
        return W'(s);
    endfunction

    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} - {1'b0, y};
        if (x < y) s = s + Q_X;
        return W'(s);
    endfunction

    // x*2^-W mod Q; x < Q*2^W so the shifted sum is below 2Q and one subtract suffices
    function automatic logic [W-1:0] mont(input logic [2*W-1:0] x);
        logic [W-1:0]   m;
        logic [2*W-1:0] mq;
        logic [2*W:0]   t;
        m  = x[W-1:0] * QINV_W;
        mq = (2*W)'(m) * (2*W)'(Q_W);
        t  = ({1'b0, x} + {1'b0, mq}) >> W;
        if (t >= Q_M) t = t - Q_M;
        return W'(t);
    endfunction

    function automatic logic [W-1:0] half(input logic [W-1:0] x);
        logic [W:0] s;
        s = x[0] ? ({1'b0, x} + Q_X) : {1'b0, x};
        return W'(s >> 1);
    endfunction

    logic             w_adv;
    logic [W-1:0]     w_s1_a, w_s1_b, w_s2_b, w_s3_c, w_s3_d, w_s4_c, w_s4_d;
    logic [2*W-1:0]   w_p1, w_p2;

    logic             r_s1_v, r_s2_v, r_s3_v;
    logic [1:0]       r_s1_mode, r_s2_mode, r_s3_mode;
    logic [TAG_W-1:0] r_s1_tag, r_s2_tag, r_s3_tag;
    logic [W-1:0]     r_s1_a, r_s1_b, r_s1_w, r_s2_a, r_s2_b, r_s3_c, r_s3_d;
    logic [2*W-1:0]   r_s1_p, r_s2_p;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;
    assign w_p1     = (2*W)'(in_b) * (2*W)'(in_w);
    assign w_p2     = (2*W)'(r_s1_b) * (2*W)'(r_s1_w);

    // Per-stage datapath: NTT multiplies first, INTT adds/subtracts first
    always_comb begin
        w_s1_a = in_a;
        w_s1_b = in_b;
        if (in_mode == MODE_INTT) begin
            w_s1_a = add_mod(in_a, in_b);
            w_s1_b = sub_mod(in_a, in_b);
        end
        w_s2_b = r_s1_b;
        if (r_s1_mode == MODE_NTT) w_s2_b = mont(r_s1_p);
        w_s3_c = r_s2_a;
        w_s3_d = r_s2_b;
        if (r_s2_mode == MODE_NTT) begin
            w_s3_c = add_mod(r_s2_a, r_s2_b);
            w_s3_d = sub_mod(r_s2_a, r_s2_b);
        end else if (r_s2_mode == MODE_INTT) begin
            w_s3_d = mont(r_s2_p);
        end
        w_s4_c = r_s3_c;
        w_s4_d = r_s3_d;
        if (HALF_INTT != 0 && r_s3_mode == MODE_INTT) begin
            w_s4_c = half(r_s3_c);
            w_s4_d = half(r_s3_d);
        end
    end

    // All stages advance together; idle beats are accepted but never marked valid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v <= 1'b0; r_s2_v <= 1'b0; r_s3_v <= 1'b0; out_valid <= 1'b0;
            r_s1_mode <= '0; r_s2_mode <= '0; r_s3_mode <= '0; out_mode <= '0;
            r_s1_tag <= '0; r_s2_tag <= '0; r_s3_tag <= '0; out_tag <= '0;
            r_s1_a <= '0; r_s1_b <= '0; r_s1_w <= '0; r_s1_p <= '0;
            r_s2_a <= '0; r_s2_b <= '0; r_s2_p <= '0;
            r_s3_c <= '0; r_s3_d <= '0;
            out_c <= '0; out_d <= '0;
        end else if (w_adv) begin
            r_s1_v    <= in_valid && (in_mode != MODE_IDLE);
            r_s1_mode <= in_mode;
            r_s1_tag  <= in_tag;
            r_s1_a    <= w_s1_a;
            r_s1_b    <= w_s1_b;
            r_s1_w    <= in_w;
            r_s1_p    <= w_p1;
            r_s2_v    <= r_s1_v;
            r_s2_mode <= r_s1_mode;
            r_s2_tag  <= r_s1_tag;
            r_s2_a    <= r_s1_a;
            r_s2_b    <= w_s2_b;
            r_s2_p    <= w_p2;
            r_s3_v    <= r_s2_v;
            r_s3_mode <= r_s2_mode;
            r_s3_tag  <= r_s2_tag;
            r_s3_c    <= w_s3_c;
            r_s3_d    <= w_s3_d;
            out_valid <= r_s3_v;
            out_mode  <= r_s3_mode;
            out_tag   <= r_s3_tag;
            out_c     <= w_s4_c;
            out_d     <= w_s4_d;
        end
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed and small randomised checks of butterfly_pipe (W=16, Q=3329, HALF_INTT=1).
module tb_butterfly_pipe;

    localparam int unsigned W     = 16;
    localparam int unsigned Q     = 3329;
    localparam int unsigned TAG_W = 8;
    localparam longint      RINV  = 169;   // 2^-16 mod 3329
    localparam longint      INV2  = 1665;  // 2^-1 mod 3329

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [1:0]       mode;
        logic [W-1:0]     c;
        logic [W-1:0]     d;
    } beat_t;

    logic clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [1:0] in_mode, out_mode;
    logic [W-1:0] in_a, in_b, in_w, out_c, out_d;
    logic [TAG_W-1:0] in_tag, out_tag;

    int n_checks = 0;
    int n_pass   = 0;
    beat_t obs_q[$];
    beat_t exp_q[$];
    logic drv_done;

    butterfly_pipe #(.W(W), .Q(Q), .QINV(3327), .TAG_W(TAG_W), .HALF_INTT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_a(in_a), .in_b(in_b), .in_w(in_w), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_c(out_c), .out_d(out_d), .out_tag(out_tag), .out_mode(out_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && out_valid && out_ready) obs_q.push_back('{out_tag, out_mode, out_c, out_d});

    // Called at posedge+1; returns at posedge+1 just after the handshake edge
    task automatic drive_beat(input logic [1:0] m, input int a, input int b, input int w,
                              input logic [TAG_W-1:0] t);
        bit got;
        assert (a < Q && b < Q && w < Q) else $error("FAIL input_range a=%0d b=%0d w=%0d", a, b, w);
        in_valid = 1'b1; in_mode = m; in_a = W'(a); in_b = W'(b); in_w = W'(w); in_tag = t;
        got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) begin got = 1'b1; break; end
        end
        if (!got) begin n_checks++; $display("FAIL handshake_timeout tag=%h", t); end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_obs(input int n, input int budget);
        bit got;
        got = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (obs_q.size() >= n) begin got = 1'b1; break; end
        end
        if (!got) begin n_checks++; $display("FAIL obs_timeout got=%0d want=%0d", obs_q.size(), n); end
        @(posedge clk); #1;
    endtask

    function automatic beat_t model(input logic [1:0] m, input int a, input int b, input int w,
                                    input logic [TAG_W-1:0] t);
        longint la, lb, lw, tt, c, d;
        la = a; lb = b; lw = w;
        case (m)
            2'b00: begin
                tt = (lb * lw % Q) * RINV % Q;
                c = (la + tt) % Q; d = (la - tt + Q) % Q;
            end
            2'b01: begin
                c = (la + lb) % Q * INV2 % Q;
                d = ((la - lb + Q) % Q) * lw % Q * RINV % Q * INV2 % Q;
            end
            default: begin c = la; d = lb; end
        endcase
        return '{t, m, W'(c), W'(d)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b want=0", out_valid); else n_pass++;
        n_checks++; if (out_c !== '0) $display("FAIL rst_out_c got=%0d want=0", out_c); else n_pass++;
        n_checks++; if (out_d !== '0) $display("FAIL rst_out_d got=%0d want=0", out_d); else n_pass++;
        n_checks++; if (out_tag !== '0) $display("FAIL rst_out_tag got=%h want=0", out_tag); else n_pass++;
        n_checks++; if (out_mode !== 2'b00) $display("FAIL rst_out_mode got=%b want=00", out_mode); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b want=1", in_ready); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_ntt_latency();
        int lat;
        out_ready = 1'b1;
        obs_q.delete();
        drive_beat(2'b00, 100, 50, 2285, 8'hA1);
        lat = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (out_valid) begin lat = n; break; end
        end
        n_checks++; if (lat !== 4) $display("FAIL ntt_latency got=%0d want=4", lat); else n_pass++;
        n_checks++; if (out_c !== 16'd150) $display("FAIL ntt_c got=%0d want=150", out_c); else n_pass++;
        n_checks++; if (out_d !== 16'd50) $display("FAIL ntt_d got=%0d want=50", out_d); else n_pass++;
        n_checks++; if (out_tag !== 8'hA1) $display("FAIL ntt_tag got=%h want=a1", out_tag); else n_pass++;
        n_checks++; if (out_mode !== 2'b00) $display("FAIL ntt_mode got=%b want=00", out_mode); else n_pass++;
        @(posedge clk); #1;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_ntt_wrap();
        obs_q.delete();
        drive_beat(2'b00, 3000, 1000, 2285, 8'hB0);
        drive_beat(2'b00, 10, 20, 2285, 8'hB1);
        wait_obs(2, 30);
        if (obs_q.size() >= 2) begin
            n_checks++; if (obs_q[0].c !== 16'd671) $display("FAIL wrap_c got=%0d want=671", obs_q[0].c); else n_pass++;
            n_checks++; if (obs_q[0].d !== 16'd2000) $display("FAIL wrap_d got=%0d want=2000", obs_q[0].d); else n_pass++;
            n_checks++; if (obs_q[1].c !== 16'd30) $display("FAIL under_c got=%0d want=30", obs_q[1].c); else n_pass++;
            n_checks++; if (obs_q[1].d !== 16'd3319) $display("FAIL under_d got=%0d want=3319", obs_q[1].d); else n_pass++;
        end
    endtask

    task automatic test_intt_half();
        obs_q.delete();
        drive_beat(2'b01, 100, 50, 2285, 8'hC0);
        drive_beat(2'b01, 1, 0, 2285, 8'hC1);
        wait_obs(2, 30);
        if (obs_q.size() >= 2) begin
            n_checks++; if (obs_q[0].c !== 16'd75) $display("FAIL intt_c got=%0d want=75", obs_q[0].c); else n_pass++;
            n_checks++; if (obs_q[0].d !== 16'd25) $display("FAIL intt_d got=%0d want=25", obs_q[0].d); else n_pass++;
            n_checks++; if (obs_q[1].c !== 16'd1665) $display("FAIL intt_odd_c got=%0d want=1665", obs_q[1].c); else n_pass++;
            n_checks++; if (obs_q[1].d !== 16'd1665) $display("FAIL intt_odd_d got=%0d want=1665", obs_q[1].d); else n_pass++;
            n_checks++; if (obs_q[1].mode !== 2'b01) $display("FAIL intt_mode got=%b want=01", obs_q[1].mode); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        beat_t exp_b[6];
        beat_t snap;
        exp_b[0] = '{8'h10, 2'b00, 16'd12,   16'd3327};
        exp_b[1] = '{8'h11, 2'b01, 16'd7,    16'd3};
        exp_b[2] = '{8'h13, 2'b10, 16'd1234, 16'd3328};
        exp_b[3] = '{8'h14, 2'b00, 16'd338,  16'd2991};
        exp_b[4] = '{8'h16, 2'b01, 16'd3328, 16'd0};
        exp_b[5] = '{8'h17, 2'b00, 16'd3327, 16'd0};
        obs_q.delete();
        out_ready = 1'b1;
        fork
            begin
                drive_beat(2'b00, 5, 7, 2285, 8'h10);
                drive_beat(2'b01, 10, 4, 2285, 8'h11);
                drive_beat(2'b11, 77, 88, 99, 8'h12);
                drive_beat(2'b10, 1234, 3328, 5, 8'h13);
                drive_beat(2'b00, 0, 2, 1, 8'h14);
                drive_beat(2'b11, 1, 2, 3, 8'h15);
                drive_beat(2'b01, 3328, 3328, 2285, 8'h16);
                drive_beat(2'b00, 3328, 3328, 2285, 8'h17);
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                snap = '{out_tag, out_mode, out_c, out_d};
                n_checks++; if (out_valid !== 1'b1) $display("FAIL stall_valid got=%b want=1", out_valid); else n_pass++;
                n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got=%b want=0", in_ready); else n_pass++;
                for (int s = 0; s < 2; s++) begin
                    @(posedge clk);
                    @(negedge clk);
                    n_checks++;
                    if (out_valid !== 1'b1 || {out_tag, out_mode, out_c, out_d} !== snap)
                        $display("FAIL stall_hold got=%b/%h/%0d/%0d want=1/%h/%0d/%0d",
                                 out_valid, out_tag, out_c, out_d, snap.tag, snap.c, snap.d);
                    else n_pass++;
                    n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready2 got=%b want=0", in_ready); else n_pass++;
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_obs(6, 60);
        repeat (10) @(posedge clk); #1;
        n_checks++; if (obs_q.size() !== 6) $display("FAIL stream_count got=%0d want=6", obs_q.size()); else n_pass++;
        for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_b[i])
                $display("FAIL stream_beat%0d got=%h/%b/%0d/%0d want=%h/%b/%0d/%0d", i,
                         obs_q[i].tag, obs_q[i].mode, obs_q[i].c, obs_q[i].d,
                         exp_b[i].tag, exp_b[i].mode, exp_b[i].c, exp_b[i].d);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midflight();
        obs_q.delete();
        out_ready = 1'b1;
        drive_beat(2'b00, 100, 50, 2285, 8'hD0);
        drive_beat(2'b01, 200, 30, 2285, 8'hD1);
        drive_beat(2'b10, 300, 40, 7, 8'hD2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_valid got=%b want=0", out_valid); else n_pass++;
        n_checks++; if (out_c !== '0 || out_d !== '0) $display("FAIL midrst_data got=%0d/%0d want=0/0", out_c, out_d); else n_pass++;
        n_checks++; if (out_tag !== '0) $display("FAIL midrst_tag got=%h want=0", out_tag); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready got=%b want=1", in_ready); else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++; if (obs_q.size() !== 0) $display("FAIL midrst_stale got=%0d want=0", obs_q.size()); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int a, b, w;
        logic [1:0] m;
        obs_q.delete();
        exp_q.delete();
        drv_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    m = 2'($urandom_range(0, 3));
                    a = int'($urandom_range(0, Q - 1));
                    b = int'($urandom_range(0, Q - 1));
                    w = int'($urandom_range(0, Q - 1));
                    if (m != 2'b11) exp_q.push_back(model(m, a, b, w, TAG_W'(i)));
                    drive_beat(m, a, b, w, TAG_W'(i));
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        wait_obs(exp_q.size(), 100);
        n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL rand_beat%0d got=%h/%b/%0d/%0d want=%h/%b/%0d/%0d", i,
                         obs_q[i].tag, obs_q[i].mode, obs_q[i].c, obs_q[i].d,
                         exp_q[i].tag, exp_q[i].mode, exp_q[i].c, exp_q[i].d);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mode = 2'b00; in_a = '0; in_b = '0; in_w = '0;
        in_tag = '0; out_ready = 1'b0; drv_done = 1'b0;
        test_reset();
        test_ntt_latency();
        test_ntt_wrap();
        test_intt_half();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
